// File: rtl/des_output_unloader_if.sv
`default_nettype none
// ============================================================================
// Module   : des_output_unloader_if
// Brief    : Handshake bundle between the DES result path, the TX FIFO and
//            the output unloader.
// Revision : 1.0
// ============================================================================
interface des_output_unloader_if #(
    parameter int BLOCK_W = 64,
    parameter int BYTE_W  = 8
);
    logic               data_out;
    logic [BLOCK_W-1:0] block_in;
    logic               fifo_full;
    logic [BYTE_W-1:0]  tx_wdata;
    logic               tx_write;
    logic               empty;
    logic               busy;
    logic [3:0]         byte_count;

    modport master (
        output data_out, block_in, fifo_full,
        input  tx_wdata, tx_write, empty, busy, byte_count
    );

    modport slave (
        input  data_out, block_in, fifo_full,
        output tx_wdata, tx_write, empty, busy, byte_count
    );
endinterface
`default_nettype wire

// File: rtl/des_output_unloader.sv
`default_nettype none
// ============================================================================
// Module   : des_output_unloader
// Brief    : Latches a finished DES block and writes it MSB-first, one byte per
//            cycle, into the TX FIFO under back-pressure; pulses empty when done.
//            Optional macro DES_UNLOAD_CHECKSUM_EN appends an XOR checksum byte.
// Revision : 1.0
// ============================================================================
module des_output_unloader #(
    parameter int BLOCK_W = 64,
    parameter int BYTE_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    des_output_unloader_if.slave bus
);
    localparam int NUM_BYTES = BLOCK_W / BYTE_W;
`ifdef DES_UNLOAD_CHECKSUM_EN
    localparam int LAST = NUM_BYTES + 1;
`else
    localparam int LAST = NUM_BYTES;
`endif
    localparam logic [3:0] LAST_M1 = 4'(LAST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [BLOCK_W-1:0] shift_reg;
    logic [3:0]         count;
    logic               write;
    logic [BYTE_W-1:0]  top_byte;

    assign top_byte = shift_reg[BLOCK_W-1 -: BYTE_W];

`ifdef DES_UNLOAD_CHECKSUM_EN
    localparam logic [3:0] DATA_N = 4'(NUM_BYTES);
    logic [BYTE_W-1:0] csum;
    logic              data_phase;

    // Once all data bytes are out, the checksum byte takes over the data bus.
    assign data_phase   = (count < DATA_N);
    assign bus.tx_wdata = (state == SEND && !data_phase) ? csum : top_byte;
`else
    assign bus.tx_wdata = top_byte;
`endif

    assign bus.tx_write   = write;
    assign bus.empty      = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.byte_count = count;

    always_comb begin
        state_nxt = state;
        write     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.data_out) state_nxt = SEND;
            end
            SEND: begin
                write = !bus.fifo_full;
                if (write && count == LAST_M1) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
`ifdef DES_UNLOAD_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.data_out) begin
                shift_reg <= bus.block_in;
                count     <= '0;
`ifdef DES_UNLOAD_CHECKSUM_EN
                csum      <= '0;
`endif
            end else if (write) begin
                count <= count + 4'd1;
`ifdef DES_UNLOAD_CHECKSUM_EN
                if (data_phase) begin
                    shift_reg <= shift_reg << BYTE_W;
                    csum      <= csum ^ top_byte;
                end
`else
                shift_reg <= shift_reg << BYTE_W;
`endif
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_des_output_unloader.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_output_unloader
// Brief    : Scoreboard bench: expected bytes are queued per block, a monitor
//            checks every FIFO write and empty pulse against the queue.
// Revision : 1.0
// ============================================================================
module tb_des_output_unloader;
`ifdef DES_UNLOAD_CHECKSUM_EN
    localparam int LAST = 9;
`else
    localparam int LAST = 8;
`endif
    localparam int END_MARK = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];

    des_output_unloader_if #(.BLOCK_W(64), .BYTE_W(8)) bus ();

    des_output_unloader #(.BLOCK_W(64), .BYTE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream for one block: bytes MSB first, optional XOR byte, end marker.
    task automatic push_block(input logic [63:0] blk);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = 8'((blk >> (56 - 8 * i)) & 64'hFF);
            x = x ^ b;
            exp_q.push_back(int'(b));
        end
        if (LAST == 9) exp_q.push_back(int'(x));
        exp_q.push_back(END_MARK);
    endtask

    // Monitor
    always @(negedge clk) begin
        int e;
        if (!rst && bus.tx_write) begin
            check("write_while_full", bus.fifo_full, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("tx_wdata", 64'(bus.tx_wdata), 64'(e));
            end
        end
        if (!rst && bus.empty) begin
            check("empty_count", 64'(bus.byte_count), 64'(LAST));
            if (exp_q.size() == 0) begin
                check("unexpected_empty", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("empty_at_block_end", 64'(e), 64'(END_MARK));
            end
        end
    end

    // Send one block. Fifo_full pattern is either random or a fixed window.
    task automatic run_block(input logic [63:0] blk, input int hold, input bit rnd,
                             input int st_lo, input int st_hi, input bit scramble);
        bit f[64];
        int w;
        int exp_cyc;
        int got;
        for (int k = 0; k < 64; k++) begin
            if (rnd) f[k] = (k <= 40) && ($urandom_range(0, 2) == 0);
            else     f[k] = (k >= st_lo) && (k <= st_hi);
        end
        w = 0;
        exp_cyc = 0;
        for (int k = 1; k < 64; k++) begin
            if (exp_cyc == 0) begin
                if (w == LAST) exp_cyc = k;
                else if (!f[k]) w++;
            end
        end
        push_block(blk);
        bus.block_in  = blk;
        bus.data_out  = 1'b1;
        bus.fifo_full = 1'b0;
        @(posedge clk); #1;
        got = 0;
        for (int k = 1; k < 64; k++) begin
            bus.data_out  = (k <= hold);
            bus.fifo_full = f[k];
            if (scramble) bus.block_in = {$urandom, $urandom};
            @(negedge clk);
            if (k == 1) check("busy_in_send", bus.busy, 1'b1);
            if (bus.empty) begin
                got = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("empty_cycle", 64'(got), 64'(exp_cyc));
        @(posedge clk); #1;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_write", bus.tx_write, 1'b0);
        check("idle_wdata", 64'(bus.tx_wdata), 64'h0);
    endtask

    initial begin
        int n;
        bus.data_out  = 1'b0;
        bus.block_in  = '0;
        bus.fifo_full = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_write", bus.tx_write, 1'b0);
        check("rst_empty", bus.empty, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_count", 64'(bus.byte_count), 64'h0);
        check("rst_wdata", 64'(bus.tx_wdata), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Plain latency, then stall in cycles 3-5.
        run_block(64'h0123456789ABCDEF, 0, 1'b0, 99, 0, 1'b0);
        run_block(64'h0123456789ABCDEF, 0, 1'b0, 3, 5, 1'b0);
        // block_in scrambled and data_out held for three cycles.
        run_block(64'h1122334455667788, 3, 1'b0, 99, 0, 1'b1);
        run_block(64'h0102040810204080, 0, 1'b0, 99, 0, 1'b0);

        // Reset after the fourth write discards the rest of the block.
        push_block(64'hDEADBEEFCAFEF00D);
        bus.block_in = 64'hDEADBEEFCAFEF00D;
        bus.data_out = 1'b1;
        @(posedge clk); #1;
        bus.data_out = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (bus.tx_write) n++;
            @(posedge clk); #1;
        end
        check("writes_before_rst", 64'(n), 64'd4);
        rst = 1'b1;
        bus.fifo_full = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.fifo_full = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_write", bus.tx_write, 1'b0);
        check("post_rst_busy", bus.busy, 1'b0);
        check("post_rst_count", 64'(bus.byte_count), 64'h0);
        @(posedge clk); #1;
        run_block(64'hFEDCBA9876543210, 0, 1'b0, 99, 0, 1'b0);

        // Randomized blocks with random back-pressure.
        for (int i = 0; i < 25; i++) begin
            run_block({$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b1, 0, 0,
                      1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
